sd_cmd_engine: RTL and testbench
================================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 Parameter CLK_DIV, default 62: sd_clk half-period = CLK_DIV+1 clk_clk cycles (50 MHz -> ~397 kHz).
REQ-002 Parameter RESP_TIMEOUT, default 64: sd_clk rising edges allowed between end of command and response start bit.
REQ-003 clk_clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_start  in  1  one-cycle request pulse; ignored while busy=1.
REQ-006 cmd_index  in  6  command index, captured on accepted cmd_start.
REQ-007 cmd_arg  in  32  command argument, captured on accepted cmd_start.
REQ-008 resp_type  in  2  00 none, 01 48-bit (R1/R3/R6/R7), 10 136-bit (R2), 11 treated as 01; captured on accepted cmd_start.
REQ-009 busy  out  1  high from the cycle after an accepted cmd_start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 resp_data  out  128  48-bit: [37:32] index, [31:0] payload, rest 0; 136-bit: [127:1] CID/CSD bits 127:1, [0]=0.
REQ-012 crc_err  out  1  response CRC7 mismatch, valid with done, held until next accepted cmd_start.
REQ-013 timeout  out  1  no response start bit, valid with done, held until next accepted cmd_start.
REQ-014 sd_clk  out  1  card clock pin.
REQ-015 sd_cmd_out / sd_cmd_oe / sd_cmd_in  out/out/in  1 each  CMD line data, output enable, sampled input (tri-state buffer external).

Function
REQ-016 sd_clk SHALL toggle continuously from a counter reloaded at CLK_DIV; "rise"/"fall" strobes are single clk_clk cycles.
REQ-017 Outputs SHALL change only on fall strobes; sd_cmd_in SHALL be sampled only on rise strobes.
REQ-018 States: IDLE, SEND, WAIT_RESP, RECV, GAP; IDLE->SEND on accepted cmd_start.
REQ-019 SEND SHALL shift 48 bits MSB-first: 0, 1, cmd_index, cmd_arg, CRC7, 1, with sd_cmd_oe=1.
REQ-020 CRC7 SHALL use polynomial x^7+x^3+1, init 0, over the 40 bits preceding it.
REQ-021 After bit 48: resp_type=00 -> GAP; else sd_cmd_oe=0 and -> WAIT_RESP.
REQ-022 WAIT_RESP SHALL enter RECV on first sampled 0; after RESP_TIMEOUT rises without it, set timeout=1 and -> GAP.
REQ-023 RECV SHALL capture 47 (48-bit) or 135 (136-bit) further bits including the start bit's successors, then -> GAP.
REQ-024 Response CRC7 SHALL be computed over bits 47:8 (48-bit) or 127:8 of the 136-bit frame excluding the 8 header bits, compared against received bits 7:1.
REQ-025 GAP SHALL hold sd_cmd_oe=0 for 8 sd_clk rises, then pulse done and return to IDLE.
REQ-026 cmd_start together with done SHALL be ignored; a new command requires cmd_start while busy=0.

Reset
REQ-027 On reset_reset_n low, asynchronously: state IDLE, busy=0, done=0, crc_err=0, timeout=0, resp_data=0, sd_clk=0, sd_cmd_oe=0, sd_cmd_out=1, divider counter=0.
REQ-028 Reset mid-transfer SHALL abort immediately with no done pulse; after release the block SHALL accept a new cmd_start.

Configuration
REQ-029 Macro SD_CMD_RESP_CRC_EN defined: REQ-024 check active and crc_err reported.
REQ-030 Macro undefined: response CRC logic absent, crc_err tied 0; all other behaviour identical.

Verification
REQ-031 CMD0, arg 0, resp_type 00 -> CMD line carries 0x400000000095, done after 48+8 sd_clk rises, crc_err=0, timeout=0.
REQ-032 CMD8, arg 0x000001AA, resp_type 01, card model replies 0x08000001AA13 -> frame 0x48000001AA87, resp_data[37:0]=0x08000001AA, crc_err=0.
REQ-033 Same as REQ-032 with response payload bit 0 flipped -> crc_err=1 (macro defined), crc_err=0 (macro undefined).
REQ-034 CMD55, resp_type 01, CMD line held 1 -> timeout=1 after 64 rises in WAIT_RESP, resp_data=0.
REQ-035 CMD2, resp_type 10, 136-bit CID with valid CRC -> resp_data[127:1] matches CID, crc_err=0.
REQ-036 reset_reset_n low at bit 20 of SEND -> sd_cmd_oe=0, busy=0 immediately, no done; next CMD0 completes per REQ-031.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line engine: sends a 48-bit command frame with CRC7 and
// optionally receives a 48-bit or 136-bit response on the CMD pin.
// Optional macro SD_CMD_RESP_CRC_EN enables the response CRC7 check
// (crc_err); when it is undefined crc_err is tied low.
module sd_cmd_engine #(
   parameter int CLK_DIV      = 62,
   parameter int RESP_TIMEOUT = 64
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   input  logic         cmd_start,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   output logic         busy,
   output logic         done,
   output logic [127:0] resp_data,
   output logic         crc_err,
   output logic         timeout,
   output logic         sd_clk,
   output logic         sd_cmd_out,
   output logic         sd_cmd_oe,
   input  logic         sd_cmd_in
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, GAP} state_t;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   state_t         state_q, state_d;
   logic [15:0]    div_q, div_d;
   logic           sd_clk_q, sd_clk_d;
   logic [15:0]    cnt_q, cnt_d;         // bits sent / rises waited / bits received / gap rises
   logic [47:0]    shift_q, shift_d;
   logic [127:1]   rx_q, rx_d;           // response frame bits 127:1 (header and end bit dropped)
   logic           long_q, long_d;
   logic           none_q, none_d;
   logic           to_flag_q, to_flag_d;
   logic           cmd_out_q, cmd_out_d;
   logic           cmd_oe_q, cmd_oe_d;
   logic           done_q, done_d;
   logic [127:0]   resp_data_q, resp_data_d;
   logic           timeout_q, timeout_d;

   logic           rise, fall, accept, pub;
   logic [7:0]     bit_idx;

   assign rise    = (div_q == 16'd0) && !sd_clk_q;
   assign fall    = (div_q == 16'd0) && sd_clk_q;
   assign accept  = (state_q == IDLE) && cmd_start && !done_q;
   assign pub     = (state_q == GAP) && fall && (cnt_q == 16'd8);
   // frame bit position of the bit sampled on this rise while in RECV
   assign bit_idx = (long_q ? 8'd135 : 8'd47) - cnt_q[7:0];

   // clock divider, command/response FSM next state and registered outputs
   always_comb begin
      state_d     = state_q;
      div_d       = (div_q == 16'd0) ? 16'(CLK_DIV) : div_q - 16'd1;
      sd_clk_d    = (div_q == 16'd0) ? ~sd_clk_q : sd_clk_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      rx_d        = rx_q;
      long_d      = long_q;
      none_d      = none_q;
      to_flag_d   = to_flag_q;
      cmd_out_d   = cmd_out_q;
      cmd_oe_d    = cmd_oe_q;
      done_d      = 1'b0;
      resp_data_d = resp_data_q;
      timeout_d   = timeout_q;
      case (state_q)
         IDLE: if (accept) begin
            shift_d   = {2'b01, cmd_index, cmd_arg, crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
            long_d    = (resp_type == 2'b10);
            none_d    = (resp_type == 2'b00);
            cnt_d     = '0;
            rx_d      = '0;
            to_flag_d = 1'b0;
            timeout_d = 1'b0;
            state_d   = SEND;
         end
         SEND: if (fall) begin
            if (cnt_q == 16'd48) begin
               // last bit has been held for a full sd_clk period; release the line
               cmd_oe_d  = 1'b0;
               cmd_out_d = 1'b1;
               cnt_d     = '0;
               state_d   = none_q ? GAP : WAIT_RESP;
            end else begin
               cmd_oe_d  = 1'b1;
               cmd_out_d = shift_q[47];
               shift_d   = {shift_q[46:0], 1'b0};
               cnt_d     = cnt_q + 16'd1;
            end
         end
         WAIT_RESP: if (rise) begin
            if (!sd_cmd_in) begin
               cnt_d   = 16'd1;              // start bit counts as received
               state_d = RECV;
            end else if (cnt_q == 16'(RESP_TIMEOUT - 1)) begin
               to_flag_d = 1'b1;
               cnt_d     = '0;
               state_d   = GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RECV: if (rise) begin
            if (bit_idx >= 8'd1 && bit_idx <= 8'd127) rx_d[bit_idx[6:0]] = sd_cmd_in;
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == (long_q ? 16'd135 : 16'd47)) begin
               cnt_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (rise && cnt_q < 16'd8) cnt_d = cnt_q + 16'd1;
            if (pub) begin
               done_d      = 1'b1;
               timeout_d   = to_flag_q;
               resp_data_d = long_q ? {rx_q[127:1], 1'b0} : {90'b0, rx_q[45:8]};
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset aborts any transfer immediately
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= IDLE;
         div_q       <= '0;
         sd_clk_q    <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         rx_q        <= '0;
         long_q      <= 1'b0;
         none_q      <= 1'b0;
         to_flag_q   <= 1'b0;
         cmd_out_q   <= 1'b1;
         cmd_oe_q    <= 1'b0;
         done_q      <= 1'b0;
         resp_data_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         sd_clk_q    <= sd_clk_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         long_q      <= long_d;
         none_q      <= none_d;
         to_flag_q   <= to_flag_d;
         cmd_out_q   <= cmd_out_d;
         cmd_oe_q    <= cmd_oe_d;
         done_q      <= done_d;
         resp_data_q <= resp_data_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef SD_CMD_RESP_CRC_EN
   logic [6:0] rcrc_q, rcrc_d;
   logic       crc_err_q, crc_err_d;
   logic       rx_in_crc;

   // accumulate CRC over the protected response bits; publish mismatch with done
   always_comb begin
      rcrc_d    = rcrc_q;
      crc_err_d = crc_err_q;
      rx_in_crc = long_q ? (cnt_q >= 16'd8 && cnt_q < 16'd128) : (cnt_q < 16'd40);
      if (accept) begin
         rcrc_d    = '0;
         crc_err_d = 1'b0;
      end else if (state_q == RECV && rise && rx_in_crc) begin
         rcrc_d = crc7_step(rcrc_q, sd_cmd_in);
      end
      // no-response and timeout leave rx and crc at zero, which never mismatch
      if (pub) crc_err_d = (rcrc_q != rx_q[7:1]);
   end

   // response CRC registers
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rcrc_q    <= '0;
         crc_err_q <= 1'b0;
      end else begin
         rcrc_q    <= rcrc_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign crc_err = crc_err_q;
`else
   assign crc_err = 1'b0;
`endif

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign resp_data  = resp_data_q;
   assign timeout    = timeout_q;
   assign sd_clk     = sd_clk_q;
   assign sd_cmd_out = cmd_out_q;
   assign sd_cmd_oe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine with a behavioural SD card on the CMD pin.
module tb_sd_cmd_engine;

   typedef struct {
      logic [47:0]  frame;
      logic [127:0] data;
      logic         crc;
      logic         to;
      int           rises;
   } exp_t;

`ifdef SD_CMD_RESP_CRC_EN
   localparam logic CRC_FLIP = 1'b1;
`else
   localparam logic CRC_FLIP = 1'b0;
`endif

   logic         clk_clk = 1'b0;
   logic         reset_reset_n = 1'b0;
   logic         cmd_start = 1'b0;
   logic [5:0]   cmd_index = '0;
   logic [31:0]  cmd_arg = '0;
   logic [1:0]   resp_type = '0;
   logic         busy, done, crc_err, timeout, sd_clk, sd_cmd_out, sd_cmd_oe, sd_cmd_in;
   logic [127:0] resp_data;

   // card model state
   logic         card_drv = 1'b1;
   int           card_len = 0;
   logic [135:0] card_frame = '0;
   logic         sd_prev = 1'b0;
   logic [47:0]  cap = '0;
   logic [47:0]  cmd_seen = '0;
   int           cap_cnt = 0;
   int           rise_cnt = 0;
   logic         armed = 1'b0;
   int           nfall = 0;
   int           idx = 0;

   int           total = 0;
   int           bad = 0;
   exp_t         q[$];

   assign sd_cmd_in = sd_cmd_oe ? sd_cmd_out : card_drv;

   sd_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(64)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .cmd_start(cmd_start),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
      .busy(busy), .done(done), .resp_data(resp_data), .crc_err(crc_err),
      .timeout(timeout), .sd_clk(sd_clk), .sd_cmd_out(sd_cmd_out),
      .sd_cmd_oe(sd_cmd_oe), .sd_cmd_in(sd_cmd_in)
   );

   always #5 clk_clk = ~clk_clk;

   function automatic logic [6:0] crc7tb(input logic [119:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 119; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // card: captures the command on sd_clk rises, replies on falls after NCR=2
   always @(negedge clk_clk) begin
      if (!reset_reset_n) begin
         sd_prev = 1'b0; cap_cnt = 0; rise_cnt = 0; armed = 1'b0; card_drv = 1'b1;
      end else begin
         if (sd_clk && !sd_prev) begin
            if (sd_cmd_oe) begin
               if (cap_cnt == 0) rise_cnt = 0;
               cap = {cap[46:0], sd_cmd_out};
               cap_cnt++;
               if (cap_cnt == 48) begin
                  cmd_seen = cap;
                  cap_cnt  = 0;
                  if (card_len != 0) begin armed = 1'b1; nfall = 0; idx = 0; end
               end
            end
            rise_cnt++;
         end else if (!sd_clk && sd_prev && armed) begin
            nfall++;
            if (nfall >= 2) begin
               if (idx < card_len) begin
                  card_drv = card_frame[card_len - 1 - idx];
                  idx++;
               end else begin
                  card_drv = 1'b1;
                  armed    = 1'b0;
               end
            end
         end
         sd_prev = sd_clk;
      end
   end

   // monitor: every done pops one expected result
   always @(negedge clk_clk) begin
      if (reset_reset_n && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 128'(done), 128'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("cmd_frame", 128'(cmd_seen), 128'(e.frame));
            chk("resp_data", resp_data, e.data);
            chk("crc_err", 128'(crc_err), 128'(e.crc));
            chk("timeout", 128'(timeout), 128'(e.to));
            chk("sd_clk_rises", 128'(rise_cnt), 128'(e.rises));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 5000) begin @(negedge clk_clk); n++; end
      if (n >= 5000) chk("idle_wait_expired", 128'(busy), 128'(0));
   endtask

   task automatic pulse_start(input logic [5:0] ci, input logic [31:0] ca, input logic [1:0] rt);
      @(negedge clk_clk);
      cmd_index = ci; cmd_arg = ca; resp_type = rt; cmd_start = 1'b1;
      @(negedge clk_clk);
      cmd_start = 1'b0;
   endtask

   task automatic run(input logic [5:0] ci, input logic [31:0] ca, input logic [1:0] rt,
                      input int clen, input logic [135:0] cframe, input exp_t e, input bit poke);
      int n = 0;
      wait_idle();
      card_len = clen; card_frame = cframe;
      q.push_back(e);
      pulse_start(ci, ca, rt);
      if (poke) begin
         repeat (30) @(negedge clk_clk);
         chk("busy_in_send", 128'(busy), 128'(1));
         pulse_start(6'd5, 32'hFFFF_FFFF, 2'b00);   // must be ignored
      end
      while (!done && n < 5000) begin @(negedge clk_clk); n++; end
      if (n >= 5000) begin
         chk("done_wait_expired", 128'(done), 128'(1));
      end else begin
         cmd_start = 1'b1;                         // coincides with done: ignored
         @(negedge clk_clk);
         cmd_start = 1'b0;
         repeat (4) @(negedge clk_clk);
         chk("start_with_done_ignored", 128'(busy), 128'(0));
      end
   endtask

   initial begin
      exp_t e;
      logic [119:0] cid_body;
      logic [127:0] cid;
      int n;

      repeat (3) @(negedge clk_clk);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_sd_clk", 128'(sd_clk), 128'(0));
      chk("rst_oe", 128'(sd_cmd_oe), 128'(0));
      chk("rst_out", 128'(sd_cmd_out), 128'(1));
      chk("rst_resp_data", resp_data, 128'(0));
      chk("rst_crc_err", 128'(crc_err), 128'(0));
      chk("rst_timeout", 128'(timeout), 128'(0));
      reset_reset_n = 1'b1;

      // CMD0, no response: 48 bits + 8 gap rises
      e = '{48'h40_0000_0000_95, 128'h0, 1'b0, 1'b0, 56};
      run(6'd0, 32'h0, 2'b00, 0, 136'h0, e, 1'b0);

      // CMD8 with R7 echo; a second cmd_start mid-SEND is ignored
      e = '{48'h48_0000_01AA_87, 128'h08_0000_01AA, 1'b0, 1'b0, 105};
      run(6'd8, 32'h0000_01AA, 2'b01, 48, 136'h08_0000_01AA_13, e, 1'b1);

      // CMD8 with payload bit 0 flipped
      e = '{48'h48_0000_01AA_87, 128'h08_0000_01AB, CRC_FLIP, 1'b0, 105};
      run(6'd8, 32'h0000_01AA, 2'b01, 48, 136'h08_0000_01AB_13, e, 1'b0);

      // CMD55, card silent: 48 + 64 wait + 8 gap rises
      e = '{48'h77_0000_0000_65, 128'h0, 1'b0, 1'b1, 120};
      run(6'd55, 32'h0, 2'b01, 0, 136'h0, e, 1'b0);

      // CMD2 with 136-bit CID
      cid_body = 120'h03_5344_5355_3136_4780_1234_5678_0112;
      cid      = {cid_body, crc7tb(cid_body), 1'b1};
      e = '{48'h42_0000_0000_4D, {cid[127:1], 1'b0}, 1'b0, 1'b0, 193};
      run(6'd2, 32'h0, 2'b10, 136, {8'h3F, cid}, e, 1'b0);

      // resp_type 11 behaves as 48-bit
      e = '{48'h48_0000_01AA_87, 128'h08_0000_01AA, 1'b0, 1'b0, 105};
      run(6'd8, 32'h0000_01AA, 2'b11, 48, 136'h08_0000_01AA_13, e, 1'b0);

      // reset during bit 20 of SEND aborts with no done
      wait_idle();
      card_len = 0;
      pulse_start(6'd17, 32'h1234_5678, 2'b01);
      n = 0;
      while (cap_cnt != 20 && n < 5000) begin @(negedge clk_clk); n++; end
      if (n >= 5000) chk("bit20_wait_expired", 128'(cap_cnt), 128'(20));
      reset_reset_n = 1'b0;
      #1;
      chk("abort_oe", 128'(sd_cmd_oe), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_out", 128'(sd_cmd_out), 128'(1));
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      e = '{48'h40_0000_0000_95, 128'h0, 1'b0, 1'b0, 56};
      run(6'd0, 32'h0, 2'b00, 0, 136'h0, e, 1'b0);

      chk("scoreboard_drained", 128'(q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
